// File: rtl/key_pkg.sv
// ============================================================================
// Module   : key_pkg
// Purpose  : Shared key debouncer types, counter width helper, 50 MHz defaults
// Revision : 1.0
// ============================================================================
`default_nettype none

package key_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_DEB = 2'd1,
        HELD      = 2'd2,
        REL_DEB   = 2'd3
    } key_st_t;

    localparam logic [19:0] C_CNT_MAX_DEF  = 20'd999_999;     // 20 ms at 50 MHz
    localparam logic [27:0] C_LONG_MAX_DEF = 28'd49_999_999;  // 1 s at 50 MHz

    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/key_chan.sv
// ============================================================================
// Module   : key_chan
// Purpose  : One key channel: 2-FF sync, debounce FSM, optional long-press
//            counter (KEY_LONG_PRESS_EN), registered outputs
// Revision : 1.0
// ============================================================================
`default_nettype none

module key_chan
    import key_pkg::*;
#(
    parameter logic [19:0] CNT_MAX    = C_CNT_MAX_DEF,
    parameter logic [27:0] LONG_MAX   = C_LONG_MAX_DEF,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_in,
    output logic key_state,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam int            CW          = cnt_width(int'(CNT_MAX));
    localparam logic [CW-1:0] C_CNT_LAST  = CW'(CNT_MAX - 20'd1);
    localparam logic          C_KEY_IDLE  = ACTIVE_LOW;

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    key_st_t       state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          w_k_s;

    assign w_k_s = ACTIVE_LOW ? ~sync2_q : sync2_q;

    always_comb begin
        sync1_d   = key_in;
        sync2_d   = sync1_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (w_k_s) state_d = PRESS_DEB;
            end
            PRESS_DEB: begin
                if (!w_k_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == C_CNT_LAST) begin
                    state_d = HELD;
                    level_d = 1'b1;
                    press_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!w_k_s) begin
                    state_d = REL_DEB;
                    cnt_d   = '0;
                end
            end
            REL_DEB: begin
                if (w_k_s) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == C_CNT_LAST) begin
                    state_d   = IDLE;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            sync1_q   <= C_KEY_IDLE;
            sync2_q   <= C_KEY_IDLE;
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign key_state   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;

`ifdef KEY_LONG_PRESS_EN
    localparam int            LW         = cnt_width(int'(LONG_MAX));
    localparam logic [LW-1:0] C_LONG_TOP = LW'(LONG_MAX);
    localparam logic [LW-1:0] C_LONG_PRE = LW'(LONG_MAX - 28'd2);

    logic [LW-1:0] lcnt_q, lcnt_d;
    logic          long_q, long_d;

    // Release bounces keep counting; only a completed release clears the hold time.
    always_comb begin
        lcnt_d = lcnt_q;
        long_d = 1'b0;
        if (state_d == IDLE) begin
            lcnt_d = '0;
        end else if (state_q == HELD || state_q == REL_DEB) begin
            if (lcnt_q != C_LONG_TOP) lcnt_d = lcnt_q + 1'b1;
            long_d = (lcnt_q == C_LONG_PRE);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            lcnt_q <= '0;
            long_q <= 1'b0;
        end else begin
            lcnt_q <= lcnt_d;
            long_q <= long_d;
        end
    end

    assign key_long = long_q;
`else
    assign key_long = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/key_debounce_nch.sv
// ============================================================================
// Module   : key_debounce_nch
// Purpose  : N-channel key debouncer; long-press output built only when
//            KEY_LONG_PRESS_EN is defined
// Revision : 1.0
// ============================================================================
`default_nettype none

module key_debounce_nch
    import key_pkg::*;
#(
    parameter int          N_KEYS     = 4,
    parameter logic [19:0] CNT_MAX    = C_CNT_MAX_DEF,
    parameter logic [27:0] LONG_MAX   = C_LONG_MAX_DEF,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_state,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long
);

    for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_chan
        key_chan #(
            .CNT_MAX    (CNT_MAX),
            .LONG_MAX   (LONG_MAX),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_chan (
            .sys_clk     (sys_clk),
            .sys_rst_n   (sys_rst_n),
            .key_in      (key_in[gi]),
            .key_state   (key_state[gi]),
            .key_press   (key_press[gi]),
            .key_release (key_release[gi]),
            .key_long    (key_long[gi])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_key_debounce_nch.sv
// ============================================================================
// Module   : tb_key_debounce_nch
// Purpose  : Directed and randomized check of key_debounce_nch against a
//            run-length reference model (KEY_LONG_PRESS_EN aware)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_key_debounce_nch;

    localparam int N    = 4;
    localparam int CNT  = 10;
    localparam int LONG = 40;
`ifdef KEY_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic         sys_clk   = 1'b0;
    logic         sys_rst_n = 1'b0;
    logic [N-1:0] key_in    = '1;
    logic [N-1:0] key_state, key_press, key_release, key_long;

    always #5 sys_clk = ~sys_clk;

    key_debounce_nch #(
        .N_KEYS     (N),
        .CNT_MAX    (20'd10),
        .LONG_MAX   (28'd40),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .key_in      (key_in),
        .key_state   (key_state),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long)
    );

    int vectors     = 0;
    int miscompares = 0;
    int edge_no     = 0;

    // Reference model: debounced level flips after CNT+1 consecutive
    // synchronised samples disagreeing with it; hold time counts edges since press.
    logic [N-1:0] m_s1 = '1, m_s2 = '1, m_level = '0;
    logic [N-1:0] e_press = '0, e_rel = '0, e_long = '0;
    int           m_run [N];
    int           m_hold[N];

    // Per-channel event watch, indices relative to the last clear_watch.
    int w_ch, w_edge, f_press, f_rel, f_long, n_press, n_rel, n_long;

    task automatic check_bits(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s edge=%0d observed=%b expected=%b", tag, edge_no, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic smp;
        e_press = '0;
        e_rel   = '0;
        e_long  = '0;
        if (!sys_rst_n) begin
            m_s1    = '1;
            m_s2    = '1;
            m_level = '0;
            for (int i = 0; i < N; i++) begin
                m_run[i]  = 0;
                m_hold[i] = 0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                smp = ~m_s2[i];
                if (smp != m_level[i]) m_run[i]++;
                else                   m_run[i] = 0;
                if (m_run[i] == CNT + 1) begin
                    m_run[i]   = 0;
                    m_level[i] = ~m_level[i];
                    m_hold[i]  = 0;
                    if (m_level[i]) e_press[i] = 1'b1;
                    else            e_rel[i]   = 1'b1;
                end else if (m_level[i]) begin
                    if (m_hold[i] < LONG) m_hold[i]++;
                    if (m_hold[i] == LONG - 1) e_long[i] = LONG_EN;
                end
            end
            m_s2 = m_s1;
            m_s1 = key_in;
        end
    endtask

    task automatic clear_watch(input int ch);
        w_ch = ch; w_edge = 0;
        f_press = 0; f_rel = 0; f_long = 0;
        n_press = 0; n_rel = 0; n_long = 0;
    endtask

    task automatic step();
        @(posedge sys_clk);
        model_edge();
        edge_no++;
        w_edge++;
        #1;
        check_bits("state",   key_state,   m_level);
        check_bits("press",   key_press,   e_press);
        check_bits("release", key_release, e_rel);
        check_bits("long",    key_long,    e_long);
        if (key_press[w_ch])   begin n_press++; if (f_press == 0) f_press = w_edge; end
        if (key_release[w_ch]) begin n_rel++;   if (f_rel   == 0) f_rel   = w_edge; end
        if (key_long[w_ch])    begin n_long++;  if (f_long  == 0) f_long  = w_edge; end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int dur[N];

    initial begin
        clear_watch(0);
        sys_rst_n = 1'b0;
        key_in    = '1;
        steps(2);
        check_bits("reset_outputs", key_state | key_press | key_release | key_long, '0);
        sys_rst_n = 1'b1;
        steps(3);

        // 1: clean press/release on ch0
        clear_watch(0);
        key_in[0] = 1'b0;
        steps(30);
        check_int("s1_press_edge", f_press, 13);
        check_int("s1_press_count", n_press, 1);
        clear_watch(0);
        key_in[0] = 1'b1;
        steps(20);
        check_int("s1_release_edge", f_rel, 13);

        // 2: bounce rejection on ch1
        clear_watch(1);
        for (int c = 0; c < 60; c++) begin
            key_in[1] = ((c % 8) < 5) ? 1'b0 : 1'b1;
            step();
        end
        key_in[1] = 1'b1;
        steps(15);
        check_int("s2_pulses", n_press + n_rel + n_long, 0);

        // 3: long press on ch2
        clear_watch(2);
        key_in[2] = 1'b0;
        steps(100);
        check_int("s3_press_edge", f_press, 13);
        check_int("s3_long_edge", f_long, LONG_EN ? 52 : 0);
        check_int("s3_long_count", n_long, LONG_EN ? 1 : 0);
        key_in[2] = 1'b1;
        steps(20);

        // 4: simultaneous ch0/ch3
        clear_watch(1);
        key_in = 4'b0110;
        steps(12);
        step();
        check_bits("s4_simul_press", key_press, 4'b1001);
        steps(10);
        check_int("s4_quiet_ch1", n_press + n_rel, 0);
        key_in = '1;
        steps(20);

        // 5: reset mid-hold on ch0
        key_in[0] = 1'b0;
        steps(20);
        sys_rst_n = 1'b0;
        step();
        check_bits("s5_reset_outputs", key_state | key_press | key_release | key_long, '0);
        sys_rst_n = 1'b1;
        clear_watch(0);
        steps(20);
        check_int("s5_repress_edge", f_press, 13);
        check_int("s5_no_release", n_rel, 0);
        key_in[0] = 1'b1;
        steps(20);

        // 6: release glitch during ch2 hold
        clear_watch(2);
        key_in[2] = 1'b0;
        steps(30);
        key_in[2] = 1'b1;
        steps(4);
        key_in[2] = 1'b0;
        steps(30);
        check_int("s6_no_release", n_rel, 0);
        check_int("s6_long_edge", f_long, LONG_EN ? 52 : 0);
        check_bits("s6_state_held", key_state & 4'b0100, 4'b0100);
        key_in[2] = 1'b1;
        steps(20);

        // Randomized phase: independent random hold/bounce lengths, rare resets
        clear_watch(0);
        for (int i = 0; i < N; i++) dur[i] = int'($urandom_range(1, 30));
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                dur[i]--;
                if (dur[i] <= 0) begin
                    key_in[i] = ~key_in[i];
                    dur[i]    = int'($urandom_range(1, 30));
                end
            end
            sys_rst_n = ($urandom_range(0, 299) != 0);
            step();
        end
        sys_rst_n = 1'b1;
        key_in    = '1;
        steps(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
